// File: rtl/led_row_scheduler.sv
// Row scheduler for a multiplexed TLC5941 array: DC load, per-row greyscale shift, blank/latch/swap, GSCLK PWM window.
// Optional LED_UNDERRUN_CNT_EN adds a saturating underrun_count_o output.
module led_row_scheduler #(
    parameter int NUM_ROWS    = 6,
    parameter int GS_CLOCKS   = 4096,
    parameter int GS_DIV      = 8,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                enable_i,
    input  logic                dc_reload_i,
    output logic                shift_start_o,
    output logic                shift_mode_o,
    output logic [2:0]          shift_row_o,
    input  logic                shift_done_i,
    output logic                led_mode_o,
    output logic                led_xlat_o,
    output logic                led_blank_o,
    output logic                led_gsclk_o,
    output logic [NUM_ROWS-1:0] row_sel_o,
    output logic                frame_pulse_o,
`ifdef LED_UNDERRUN_CNT_EN
    output logic [15:0]         underrun_count_o,
`endif
    output logic                busy_o
);

    localparam int DW = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);
    localparam int PW = $clog2(GS_DIV);
    localparam logic [12:0]   GS_LAST   = 13'(GS_CLOCKS);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES);
    localparam logic [PW-1:0] PH_LAST   = PW'(GS_DIV - 1);
    localparam logic [PW-1:0] PH_HALF   = PW'(GS_DIV / 2);
    localparam logic [2:0]    ROW_LAST  = 3'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DC_SHIFT = 3'd1,
        ST_DC_LATCH = 3'd2,
        ST_PRIME    = 3'd3,
        ST_SWAP     = 3'd4,
        ST_DISPLAY  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic            dc_pend_q, dc_pend_d;
    logic            outst_q, outst_d;
    logic            rdy_q, rdy_d;
    logic            hold_q, hold_d;
    logic            hold_dc_q, hold_dc_d;
    logic [DW-1:0]   dead_q, dead_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [12:0]     edges_q, edges_d;
    logic            start_d, smode_d, frame_d;
    logic [2:0]      srow_d;

    function automatic logic [NUM_ROWS-1:0] onehot(input logic [2:0] r);
        return {{(NUM_ROWS-1){1'b0}}, 1'b1} << r;
    endfunction

    logic       done_rx_s, rcv_s, period_end_s, wrap_s, disp_on_s;
    logic [2:0] row_next_s;

    assign done_rx_s    = shift_done_i & outst_q;
    assign rcv_s        = rdy_q | done_rx_s;
    assign period_end_s = (state_q == ST_DISPLAY) & ~hold_q & (ph_q == PH_LAST) & (edges_q == GS_LAST);
    assign wrap_s       = (row_q == ROW_LAST);
    assign row_next_s   = wrap_s ? 3'd0 : row_q + 3'd1;
    // Hold inside DISPLAY means rows dark waiting for the shift engine (underrun or pre-DC drain).
    assign disp_on_s    = (state_d == ST_DISPLAY) & ~hold_d;

    // Next-state and handshake bookkeeping.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        dc_pend_d = dc_pend_q | dc_reload_i;
        outst_d   = outst_q & ~shift_done_i;
        rdy_d     = rdy_q;
        hold_d    = hold_q;
        hold_dc_d = hold_dc_q;
        dead_d    = dead_q;
        ph_d      = ph_q;
        edges_d   = edges_q;
        start_d   = 1'b0;
        smode_d   = shift_mode_o;
        srow_d    = shift_row_o;
        frame_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy_d  = 1'b0;
                hold_d = 1'b0;
                if (enable_i && !outst_q) begin
                    row_d   = 3'd0;
                    start_d = 1'b1;
                    outst_d = 1'b1;
                    srow_d  = 3'd0;
                    smode_d = dc_pend_q;
                    state_d = dc_pend_q ? ST_DC_SHIFT : ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DC_SHIFT: begin
                if (done_rx_s) begin
                    state_d = ST_DC_LATCH;
                end else begin
                    state_d = ST_DC_SHIFT;
                end
            end
            ST_DC_LATCH: begin
                state_d   = ST_PRIME;
                dc_pend_d = dc_reload_i;
                start_d   = 1'b1;
                outst_d   = 1'b1;
                smode_d   = 1'b0;
                srow_d    = row_q;
            end
            ST_PRIME: begin
                if (done_rx_s) begin
                    state_d = ST_SWAP;
                    dead_d  = '0;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_SWAP: begin
                if (dead_q == DEAD_LAST) begin
                    state_d = ST_DISPLAY;
                    ph_d    = '0;
                    edges_d = 13'd0;
                    rdy_d   = 1'b0;
                    hold_d  = 1'b0;
                    start_d = 1'b1;
                    outst_d = 1'b1;
                    smode_d = 1'b0;
                    srow_d  = row_next_s;
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end
            ST_DISPLAY: begin
                if (hold_q) begin
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                        hold_d  = 1'b0;
                    end else if (done_rx_s) begin
                        hold_d = 1'b0;
                        if (hold_dc_q) begin
                            state_d = ST_DC_SHIFT;
                            start_d = 1'b1;
                            outst_d = 1'b1;
                            smode_d = 1'b1;
                        end else begin
                            state_d = ST_SWAP;
                            dead_d  = '0;
                        end
                    end else begin
                        state_d = ST_DISPLAY;
                    end
                end else if (period_end_s) begin
                    frame_d = wrap_s;
                    row_d   = row_next_s;
                    rdy_d   = 1'b0;
                    ph_d    = '0;
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (dc_pend_q && wrap_s) begin
                        if (rcv_s) begin
                            state_d = ST_DC_SHIFT;
                            start_d = 1'b1;
                            outst_d = 1'b1;
                            smode_d = 1'b1;
                        end else begin
                            hold_d    = 1'b1;
                            hold_dc_d = 1'b1;
                        end
                    end else if (rcv_s) begin
                        state_d = ST_SWAP;
                        dead_d  = '0;
                    end else begin
                        hold_d    = 1'b1;
                        hold_dc_d = 1'b0;
                    end
                end else begin
                    rdy_d = rcv_s;
                    ph_d  = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
                    if (ph_d == PH_HALF) begin
                        edges_d = edges_q + 13'd1;
                    end else begin
                        edges_d = edges_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered pin outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            row_q         <= 3'd0;
            dc_pend_q     <= 1'b1;
            outst_q       <= 1'b0;
            rdy_q         <= 1'b0;
            hold_q        <= 1'b0;
            hold_dc_q     <= 1'b0;
            dead_q        <= '0;
            ph_q          <= '0;
            edges_q       <= 13'd0;
            shift_start_o <= 1'b0;
            shift_mode_o  <= 1'b0;
            shift_row_o   <= 3'd0;
            led_mode_o    <= 1'b0;
            led_xlat_o    <= 1'b0;
            led_blank_o   <= 1'b1;
            led_gsclk_o   <= 1'b0;
            row_sel_o     <= '0;
            frame_pulse_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            dc_pend_q     <= dc_pend_d;
            outst_q       <= outst_d;
            rdy_q         <= rdy_d;
            hold_q        <= hold_d;
            hold_dc_q     <= hold_dc_d;
            dead_q        <= dead_d;
            ph_q          <= ph_d;
            edges_q       <= edges_d;
            shift_start_o <= start_d;
            shift_mode_o  <= smode_d;
            shift_row_o   <= srow_d;
            led_mode_o    <= (state_d == ST_DC_SHIFT) | (state_d == ST_DC_LATCH);
            led_xlat_o    <= (state_d == ST_DC_LATCH) | ((state_d == ST_SWAP) & (dead_d == DEAD_LAST));
            led_blank_o   <= ~disp_on_s;
            led_gsclk_o   <= disp_on_s & (ph_d >= PH_HALF);
            row_sel_o     <= disp_on_s ? onehot(row_d) : '0;
            frame_pulse_o <= frame_d;
            busy_o        <= (state_d != ST_IDLE);
        end
    end

`ifdef LED_UNDERRUN_CNT_EN
    logic under_inc_s;
    assign under_inc_s = period_end_s & enable_i & ~rcv_s & ~(dc_pend_q & wrap_s);

    // Saturating count of display periods that ended before the next row was loaded.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            underrun_count_o <= 16'd0;
        end else if (under_inc_s && (underrun_count_o != 16'hFFFF)) begin
            underrun_count_o <= underrun_count_o + 16'd1;
        end else begin
            underrun_count_o <= underrun_count_o;
        end
    end
`endif

endmodule

// File: tb/tb_led_row_scheduler.sv
// Directed bench for led_row_scheduler with a behavioural shift engine answering each start after a set delay.
module tb_led_row_scheduler;
    localparam int NR = 6, GSC = 16, GSD = 8, DEAD = 16;

    logic          clock_i = 1'b0;
    logic          reset_n_i, enable_i, dc_reload_i, shift_done_i;
    logic          shift_start_o, shift_mode_o, led_mode_o, led_xlat_o, led_blank_o, led_gsclk_o;
    logic          frame_pulse_o, busy_o;
    logic [2:0]    shift_row_o;
    logic [NR-1:0] row_sel_o;
`ifdef LED_UNDERRUN_CNT_EN
    logic [15:0]   underrun_count_o;
`endif

    led_row_scheduler #(.NUM_ROWS(NR), .GS_CLOCKS(GSC), .GS_DIV(GSD), .DEAD_CYCLES(DEAD)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .dc_reload_i(dc_reload_i),
        .shift_start_o(shift_start_o), .shift_mode_o(shift_mode_o), .shift_row_o(shift_row_o),
        .shift_done_i(shift_done_i), .led_mode_o(led_mode_o), .led_xlat_o(led_xlat_o),
        .led_blank_o(led_blank_o), .led_gsclk_o(led_gsclk_o), .row_sel_o(row_sel_o),
        .frame_pulse_o(frame_pulse_o),
`ifdef LED_UNDERRUN_CNT_EN
        .underrun_count_o(underrun_count_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clock_i = ~clock_i;

    int n_cmp = 0, n_bad = 0, viol = 0;
    int done_delay = 10;
    bit hold_done = 1'b0;

    // Shift engine: answers each start with a one-cycle done after done_delay cycles unless held.
    initial begin
        bit run = 1'b0;
        int cd = 0;
        shift_done_i = 1'b0;
        forever begin
            @(posedge clock_i);
            #2;
            shift_done_i = 1'b0;
            if (!reset_n_i) begin
                run = 1'b0;
            end else begin
                if (run) begin
                    if (cd > 1) cd--;
                    else if (!hold_done) begin shift_done_i = 1'b1; run = 1'b0; end
                end
                if (shift_start_o) begin run = 1'b1; cd = done_delay; end
            end
        end
    end

    always @(negedge clock_i) begin
        if ((row_sel_o != '0 || led_gsclk_o) && led_blank_o) viol++;
    end

    int ent_cnt;
    logic [NR-1:0] ent_rs [8];
    int per_edges [8], frames_at [8], dcst_at [8], dcx_at [8], xl_at [8];

    task automatic run_entries(input int n, input int budget);
        logic [NR-1:0] prev;
        logic gp;
        int rises = 0, fr = 0, dcs = 0, dcx = 0, xl = 0;
        ent_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            ent_rs[i] = '0; per_edges[i] = -1; frames_at[i] = -1; dcst_at[i] = -1; dcx_at[i] = -1; xl_at[i] = -1;
        end
        prev = row_sel_o;
        gp = led_gsclk_o;
        for (int c = 0; c < budget && ent_cnt < n; c++) begin
            @(negedge clock_i);
            if (led_gsclk_o && !gp) rises++;
            gp = led_gsclk_o;
            if (frame_pulse_o) fr++;
            if (shift_start_o && shift_mode_o) dcs++;
            if (led_xlat_o) begin xl++; if (led_mode_o) dcx++; end
            if (row_sel_o != '0 && prev == '0) begin
                ent_rs[ent_cnt] = row_sel_o; per_edges[ent_cnt] = rises; rises = 0;
                frames_at[ent_cnt] = fr; dcst_at[ent_cnt] = dcs; dcx_at[ent_cnt] = dcx; xl_at[ent_cnt] = xl;
                ent_cnt++;
            end
            prev = row_sel_o;
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; enable_i = 1'b0; dc_reload_i = 1'b0;
        repeat (3) @(negedge clock_i);
        n_cmp++;
        if ({led_blank_o, led_xlat_o, led_mode_o, led_gsclk_o} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_pins: got %b expected 1000", {led_blank_o, led_xlat_o, led_mode_o, led_gsclk_o});
        end
        n_cmp++;
        if ({row_sel_o, shift_start_o, frame_pulse_o, busy_o} !== '0) begin
            n_bad++; $display("FAIL reset_ctl: got %b expected 0", {row_sel_o, shift_start_o, frame_pulse_o, busy_o});
        end
        reset_n_i = 1'b1;
        repeat (4) @(negedge clock_i);
        n_cmp++;
        if ({busy_o, shift_start_o, led_blank_o} !== 3'b001) begin
            n_bad++; $display("FAIL idle_hold: got %b expected 001", {busy_o, shift_start_o, led_blank_o});
        end
    endtask

    task automatic test_startup();
        bit ok = 1'b0;
        int dead = 0;
        enable_i = 1'b1;
        for (int c = 0; c < 10; c++) begin @(negedge clock_i); if (shift_start_o) begin ok = 1'b1; break; end end
        n_cmp++;
        if ({ok, shift_mode_o, led_mode_o, busy_o} !== 4'b1111) begin
            n_bad++; $display("FAIL dc_start: got %b expected 1111", {ok, shift_mode_o, led_mode_o, busy_o});
        end
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin @(negedge clock_i); if (led_xlat_o) begin ok = 1'b1; break; end end
        n_cmp++;
        if ({ok, led_mode_o, row_sel_o} !== {2'b11, 6'b0}) begin
            n_bad++; $display("FAIL dc_xlat: got %b expected 11000000", {ok, led_mode_o, row_sel_o});
        end
        @(negedge clock_i);
        n_cmp++;
        if ({led_mode_o, led_xlat_o, shift_start_o, shift_mode_o, shift_row_o} !== 7'b0010000) begin
            n_bad++; $display("FAIL prime_start: got %b expected 0010000", {led_mode_o, led_xlat_o, shift_start_o, shift_mode_o, shift_row_o});
        end
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin @(negedge clock_i); if (shift_done_i) begin ok = 1'b1; break; end end
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock_i);
            if (led_xlat_o) begin ok = 1'b1; break; end
            if (led_blank_o && row_sel_o == '0) dead++;
        end
        n_cmp++;
        if (ok !== 1'b1 || dead != DEAD) begin
            n_bad++; $display("FAIL dead_cycles: got %0d (xlat %b) expected %0d (xlat 1)", dead, ok, DEAD);
        end
        @(negedge clock_i);
        n_cmp++;
        if ({row_sel_o, led_blank_o, shift_start_o, shift_mode_o, shift_row_o} !== {6'b000001, 3'b010, 3'd1}) begin
            n_bad++; $display("FAIL row0_entry: got %b expected 000001010001", {row_sel_o, led_blank_o, shift_start_o, shift_mode_o, shift_row_o});
        end
    endtask

    task automatic test_full_frame();
        logic [NR-1:0] exp_rs [6] = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1};
        run_entries(6, 1500);
        n_cmp++;
        if (ent_cnt != 6) begin n_bad++; $display("FAIL frame_entries: got %0d expected 6", ent_cnt); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (ent_rs[i] !== exp_rs[i] || per_edges[i] != GSC) begin
                n_bad++; $display("FAIL frame_row%0d: got sel %b edges %0d expected sel %b edges %0d", i, ent_rs[i], per_edges[i], exp_rs[i], GSC);
            end
        end
        n_cmp++;
        if (frames_at[4] != 0 || frames_at[5] != 1) begin
            n_bad++; $display("FAIL frame_pulse: got %0d/%0d expected 0/1", frames_at[4], frames_at[5]);
        end
    endtask

    task automatic test_dc_reload();
        logic [NR-1:0] exp_rs [4] = '{6'd8, 6'd16, 6'd32, 6'd1};
        run_entries(2, 600);
        n_cmp++;
        if (ent_rs[1] !== 6'd4) begin n_bad++; $display("FAIL reach_row2: got %b expected 000100", ent_rs[1]); end
        dc_reload_i = 1'b1;
        @(negedge clock_i);
        dc_reload_i = 1'b0;
        run_entries(4, 1500);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ent_rs[i] !== exp_rs[i] || per_edges[i] != GSC) begin
                n_bad++; $display("FAIL dc_row%0d: got sel %b edges %0d expected sel %b edges %0d", i, ent_rs[i], per_edges[i], exp_rs[i], GSC);
            end
        end
        n_cmp++;
        if (dcst_at[2] != 0 || dcst_at[3] != 1 || dcx_at[3] != 1 || frames_at[3] != 1) begin
            n_bad++; $display("FAIL dc_frame: got starts %0d/%0d xlat %0d frames %0d expected 0/1 1 1", dcst_at[2], dcst_at[3], dcx_at[3], frames_at[3]);
        end
        n_cmp++;
        if (led_mode_o !== 1'b0) begin n_bad++; $display("FAIL dc_mode_back: got %b expected 0", led_mode_o); end
    endtask

    task automatic test_underrun();
        int bad = 0;
        hold_done = 1'b1;
        for (int c = 0; c < 300; c++) begin @(negedge clock_i); if (row_sel_o == '0) break; end
        for (int i = 0; i < 100; i++) begin
            if (!(led_blank_o && row_sel_o == '0 && !led_gsclk_o && busy_o)) bad++;
            @(negedge clock_i);
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL underrun_idle: got %0d bad cycles expected 0", bad); end
        hold_done = 1'b0;
        run_entries(1, 100);
        n_cmp++;
        if (ent_rs[0] !== 6'd2 || xl_at[0] != 1 || dcst_at[0] != 0) begin
            n_bad++; $display("FAIL underrun_swap: got sel %b xlat %0d expected 000010 1", ent_rs[0], xl_at[0]);
        end
`ifdef LED_UNDERRUN_CNT_EN
        n_cmp++;
        if (underrun_count_o !== 16'd1) begin n_bad++; $display("FAIL underrun_count: got %0d expected 1", underrun_count_o); end
`endif
    endtask

    task automatic test_disable();
        int rises = 0, starts = 0;
        bit ok = 1'b0;
        logic gp;
        run_entries(1, 300);
        done_delay = 200;
        run_entries(1, 300);
        n_cmp++;
        if (ent_rs[0] !== 6'd8) begin n_bad++; $display("FAIL reach_row3: got %b expected 001000", ent_rs[0]); end
        gp = led_gsclk_o;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock_i);
            if (c == 3) enable_i = 1'b0;
            if (led_gsclk_o && !gp) rises++;
            gp = led_gsclk_o;
            if (!busy_o) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if ({ok, led_blank_o, row_sel_o} !== {2'b11, 6'b0} || rises != GSC) begin
            n_bad++; $display("FAIL disable_idle: got idle %b blank %b edges %0d expected 1 1 %0d", ok, led_blank_o, rises, GSC);
        end
        for (int c = 0; c < 250; c++) begin @(negedge clock_i); if (shift_start_o) starts++; end
        n_cmp++;
        if (starts != 0) begin n_bad++; $display("FAIL disable_nostart: got %0d starts expected 0", starts); end
        done_delay = 10;
        enable_i = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 6; c++) begin @(negedge clock_i); if (shift_start_o) begin ok = 1'b1; break; end end
        n_cmp++;
        if ({ok, shift_mode_o, shift_row_o} !== 5'b10000) begin
            n_bad++; $display("FAIL reenable_prime: got %b expected 10000", {ok, shift_mode_o, shift_row_o});
        end
    endtask

    task automatic test_reset_mid_display();
        bit ok = 1'b0;
        for (int c = 0; c < 100; c++) begin @(negedge clock_i); if (row_sel_o != '0) break; end
        for (int c = 0; c < 20; c++) begin @(negedge clock_i); if (led_gsclk_o) break; end
        @(posedge clock_i);
        #3 reset_n_i = 1'b0;
        #1;
        n_cmp++;
        if ({led_blank_o, row_sel_o, led_gsclk_o, busy_o, shift_start_o} !== {1'b1, 6'b0, 3'b000}) begin
            n_bad++; $display("FAIL reset_mid: got %b expected 1000000000", {led_blank_o, row_sel_o, led_gsclk_o, busy_o, shift_start_o});
        end
        @(posedge clock_i);
        #3 reset_n_i = 1'b1;
        for (int c = 0; c < 6; c++) begin @(negedge clock_i); if (shift_start_o) begin ok = 1'b1; break; end end
        n_cmp++;
        if ({ok, shift_mode_o, led_mode_o} !== 3'b111) begin
            n_bad++; $display("FAIL restart_dc: got %b expected 111", {ok, shift_mode_o, led_mode_o});
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (viol != 0) begin n_bad++; $display("FAIL blank_invariant: got %0d violations expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_full_frame();
        test_dc_reload();
        test_underrun();
        test_disable();
        test_reset_mid_display();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
